// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a toggle req/ack UART transmitter.
// Includes an ack watchdog with a sticky error flag.
module uart_tx_feeder #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
  output logic          req,
  output logic [7:0]    tx_data,
  input  logic          ack,
  input  logic [31:0]   timeout,
  output logic          err,
  input  logic          err_clr,
  output logic [AW:0]   level,
  output logic          busy,
  output logic [1:0]    cst
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    st_idle = 2'b00,
    st_load = 2'b01,
    st_wait = 2'b11,
    st_done = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ack_d_q, ack_d_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          req_q, req_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic ack_x;
  logic expire;
  logic push;
  logic pop;

  assign ack_x    = ack_d_q[1] ^ ack_d_q[0];
  assign expire   = (timeout != 32'd0) && (cnt_q == 32'd1);
  assign wr_ready = enable && (level_q != FULL);
  assign push     = wr_valid && wr_ready;
  assign pop      = enable && (state_q == st_load);

  assign req     = req_q;
  assign tx_data = tx_data_q;
  assign err     = err_q;
  assign level   = level_q;
  assign cst     = state_q;
  assign busy    = (level_q != '0) || (state_q != st_idle);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        st_idle: if (level_q != '0) state_d = st_load;
        st_load: state_d = st_wait;
        st_wait: if (ack_x || expire) state_d = st_done;
        st_done: state_d = st_idle;
        default: state_d = st_idle;
      endcase
    end
  end

  // Ack beats expiry: the error path only runs when no ack edge is seen.
  always_comb begin
    ack_d_d   = ack_d_q;
    req_d     = req_q;
    tx_data_d = tx_data_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (enable) begin
      ack_d_d = {ack_d_q[0], ack};
      if (err_clr) err_d = 1'b0;
      unique case (state_q)
        st_load: begin
          tx_data_d = mem_q[rd_ptr_q];
          req_d     = ~req_q;
          cnt_d     = timeout;
        end
        st_wait: begin
          if (!ack_x) begin
            if (expire) begin
              err_d = 1'b1;
            end else if (cnt_q != 32'd0) begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_d_q   <= 2'b00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      req_q     <= 1'b0;
      tx_data_q <= 8'h00;
      cnt_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      ack_d_q   <= ack_d_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      req_q     <= req_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (AW=2, depth 4).
// Acts as host writer and as the toggling transmitter.
module tb_uart_tx_feeder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          req;
  logic [7:0]    tx_data;
  logic          ack;
  logic [31:0]   timeout;
  logic          err;
  logic          err_clr;
  logic [AW:0]   level;
  logic          busy;
  logic [1:0]    cst;

  int   total = 0;
  int   bad   = 0;
  logic req_last;

  uart_tx_feeder #(.AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .req      (req),
    .tx_data  (tx_data),
    .ack      (ack),
    .timeout  (timeout),
    .err      (err),
    .err_clr  (err_clr),
    .level    (level),
    .busy     (busy),
    .cst      (cst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cst(input logic [1:0] v);
    int n = 0;
    while (cst !== v && n < 40) begin
      tick();
      n++;
    end
    check("wait_cst", 32'(cst), 32'(v));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic serve(input logic [7:0] b);
    int n = 0;
    while (req === req_last && n < 40) begin
      tick();
      n++;
    end
    check("req_tog", 32'(req != req_last), 32'd1);
    check("tx", 32'(tx_data), 32'(b));
    req_last = req;
    tick();
    tick();
    ack = ~ack;
  endtask

  initial begin
    rstn     = 1'b0;
    enable   = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    ack      = 1'b0;
    timeout  = 32'd0;
    err_clr  = 1'b0;
    req_last = 1'b0;
    #23 rstn = 1'b1;
    tick();

    check("rst_req", 32'(req), 32'd0);
    check("rst_tx", 32'(tx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_lvl", 32'(level), 32'd0);
    check("rst_cst", 32'(cst), 32'd0);
    check("rst_rdy", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // single byte
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    check("t1_lvl1", 32'(level), 32'd1);
    check("t1_idle", 32'(cst), 32'd0);
    tick();
    check("t1_load", 32'(cst), 32'd1);
    tick();
    check("t1_req", 32'(req), 32'd1);
    check("t1_tx", 32'(tx_data), 32'hA5);
    check("t1_lvl0", 32'(level), 32'd0);
    check("t1_wait", 32'(cst), 32'd3);
    for (int i = 0; i < 6; i++) tick();
    check("t1_hold", 32'(cst), 32'd3);
    ack = 1'b1;
    tick();
    check("t1_ackx", 32'(cst), 32'd3);
    tick();
    check("t1_done", 32'(cst), 32'd2);
    check("t1_busy1", 32'(busy), 32'd1);
    tick();
    check("t1_back", 32'(cst), 32'd0);
    check("t1_busy0", 32'(busy), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    req_last = req;

    // burst to full, ack held
    wr_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      int n = 0;
      wr_data = 8'(i);
      while (!wr_ready && n < 20) begin
        tick();
        n++;
      end
      check("t2_rdy", 32'(wr_ready), 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    check("t2_full", 32'(wr_ready), 32'd0);
    check("t2_lvl", 32'(level), 32'd4);
    check("t2_wait", 32'(cst), 32'd3);
    for (int i = 1; i <= 5; i++) serve(8'(i));
    wait_idle();
    check("t2_req", 32'(req), 32'd0);
    check("t2_lvl0", 32'(level), 32'd0);

    // push in the load cycle
    wr_valid = 1'b1;
    wr_data  = 8'h11;
    tick();
    wr_data  = 8'h22;
    tick();
    check("t3_load", 32'(cst), 32'd1);
    check("t3_lvl2a", 32'(level), 32'd2);
    wr_data  = 8'h33;
    tick();
    wr_valid = 1'b0;
    check("t3_lvl2b", 32'(level), 32'd2);
    check("t3_wait", 32'(cst), 32'd3);
    serve(8'h11);
    serve(8'h22);
    serve(8'h33);
    wait_idle();
    check("t3_lvl0", 32'(level), 32'd0);

    // watchdog expiry
    timeout  = 32'd10;
    wr_valid = 1'b1;
    wr_data  = 8'h44;
    tick();
    wr_data  = 8'h55;
    tick();
    wr_valid = 1'b0;
    wait_cst(2'b11);
    req_last = req;
    check("t4_tx", 32'(tx_data), 32'h44);
    for (int i = 0; i < 9; i++) tick();
    check("t4_err0", 32'(err), 32'd0);
    check("t4_wait", 32'(cst), 32'd3);
    tick();
    check("t4_err1", 32'(err), 32'd1);
    check("t4_done", 32'(cst), 32'd2);
    serve(8'h55);
    wait_idle();
    check("t4_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4_clr", 32'(err), 32'd0);

    // ack lands on the expiry cycle
    timeout  = 32'd4;
    wr_valid = 1'b1;
    wr_data  = 8'h66;
    tick();
    wr_valid = 1'b0;
    wait_cst(2'b11);
    req_last = req;
    tick();
    tick();
    ack = ~ack;
    tick();
    check("t5_wait", 32'(cst), 32'd3);
    tick();
    check("t5_done", 32'(cst), 32'd2);
    check("t5_err", 32'(err), 32'd0);
    wait_idle();

    // enable low while waiting
    timeout  = 32'd5;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick();
    wr_valid = 1'b0;
    wait_cst(2'b11);
    req_last = req;
    enable   = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("t6_cst", 32'(cst), 32'd3);
    check("t6_err", 32'(err), 32'd0);
    check("t6_rdy", 32'(wr_ready), 32'd0);
    check("t6_req", 32'(req), 32'(req_last));
    enable = 1'b1;
    ack    = ~ack;
    wait_idle();
    check("t6_err2", 32'(err), 32'd0);

    // async reset mid-burst
    timeout  = 32'd0;
    wr_valid = 1'b1;
    wr_data  = 8'h81;
    tick();
    wr_data  = 8'h82;
    tick();
    wr_data  = 8'h83;
    tick();
    wr_valid = 1'b0;
    serve(8'h81);
    begin
      int n = 0;
      while (req === req_last && n < 40) begin
        tick();
        n++;
      end
    end
    check("t7_req1", 32'(req), 32'd1);
    check("t7_lvl1", 32'(level), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t7_req0", 32'(req), 32'd0);
    check("t7_lvl0", 32'(level), 32'd0);
    check("t7_cst", 32'(cst), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_tx", 32'(tx_data), 32'd0);
    #2 rstn = 1'b1;
    tick();
    req_last = 1'b0;
    check("t7_rdy", 32'(wr_ready), 32'd1);
    check("t7_err", 32'(err), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tick();
    wr_valid = 1'b0;
    serve(8'h99);
    wait_idle();
    check("t7_req", 32'(req), 32'd1);
    check("t7_end", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
